// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and host-side signal bundle for uart_rx_fifo.
// The slave modport is the FIFO's view of these signals; the master modport is the environment's view.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              rx_ready;
  logic [7:0]        rx_data;
  logic              rx_ready_clr;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic              rd_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;
  logic [7:0]        drop_count;
  logic              overflow_clr;

  modport master (
    output rx_ready, rx_data, rd_ready, overflow_clr,
    input  rx_ready_clr, rd_valid, rd_data, count, full, overflow, drop_count
  );

  modport slave (
    input  rx_ready, rx_data, rd_ready, overflow_clr,
    output rx_ready_clr, rd_valid, rd_data, count, full, overflow, drop_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between a UART receiver and a host: first-word fall-through read port,
// with fill level, sticky overflow and a saturating dropped-byte counter.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              ovf;
  logic [7:0]        drops;

  logic push_req;
  logic pop;
  logic is_full;
  logic push;
  logic drop;

  always_comb begin
    push_req = bus.rx_ready & ~rst;
    is_full  = (cnt == FULL_CNT);
    pop      = (cnt != '0) & bus.rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push     = push_req & (~is_full | pop);
    drop     = push_req & is_full & ~pop;
  end

  assign bus.rx_ready_clr = push_req;
  assign bus.rd_valid     = (cnt != '0);
  assign bus.full         = is_full;
  assign bus.count        = cnt;
  assign bus.overflow     = ovf;
  assign bus.drop_count   = drops;
  assign bus.rd_data      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
        2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A drop in the same cycle as overflow_clr wins: the clear restarts the tally at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf   <= 1'b0;
      drops <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (bus.overflow_clr) begin
        drops <= 8'd1;
      end else if (drops != '1) begin
        drops <= drops + 8'd1;
      end
    end else if (bus.overflow_clr) begin
      ovf   <= 1'b0;
      drops <= '0;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  byte unsigned mq[$];
  logic         m_ovf;
  int           m_drops;
  int           n_cmp = 0;
  int           n_err = 0;

  // Applies one cycle of stimulus, advances the reference model, and returns rx_ready_clr seen before the edge.
  task automatic drive(input logic rx, input logic [7:0] d, input logic rdy,
                       input logic clr, input logic r, output logic ack);
    logic pop_m, full_m, drop_m;
    rst = r;
    bus.rx_ready = rx;
    bus.rx_data = d;
    bus.rd_ready = rdy;
    bus.overflow_clr = clr;
    #1 ack = bus.rx_ready_clr;
    pop_m  = (mq.size() > 0) && rdy;
    full_m = (mq.size() == DEPTH);
    drop_m = rx && full_m && !pop_m;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_drops = 0;
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (rx && !drop_m) mq.push_back(d);
      if (drop_m) begin
        m_ovf = 1'b1;
        m_drops = clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      end else if (clr) begin
        m_ovf = 1'b0;
        m_drops = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic ack;
    drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", ack); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ack);
    n_cmp++; if (bus.count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    n_cmp++; if (bus.drop_count !== 8'd0) begin n_err++; $display("FAIL reset_drops: got %0d want 0", bus.drop_count); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ack);
  endtask

  task automatic test_basic();
    logic ack;
    byte unsigned exp;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h41 + i), 1'b0, 1'b0, 1'b0, ack);
      n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL basic_ack_hi: got %b want 1", ack); end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ack);
      n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL basic_ack_lo: got %b want 0", ack); end
    end
    n_cmp++; if (bus.count !== 5'd3) begin n_err++; $display("FAIL basic_count: got %0d want 3", bus.count); end
    for (int i = 0; i < 3; i++) begin
      exp = 8'(8'h41 + i);
      n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
        n_err++; $display("FAIL basic_read: got v=%b d=%h want v=1 d=%h", bus.rd_valid, bus.rd_data, exp);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, ack);
    end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty: got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_overflow_fill();
    logic ack;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, ack);
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL drop_ack: got %b want 1", ack); end
    drive(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, ack);
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", bus.full); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    n_cmp++; if (bus.drop_count !== 8'd2) begin n_err++; $display("FAIL ovf_drops: got %0d want 2", bus.drop_count); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(i)) begin
        n_err++; $display("FAIL ovf_drain: got v=%b d=%h want v=1 d=%h", bus.rd_valid, bus.rd_data, 8'(i));
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, ack);
    end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_full_push_pop();
    logic ack;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, ack);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, ack);
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, ack);
    n_cmp++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL fpp_count: got %0d want 16", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fpp_ovf: got %b want 0", bus.overflow); end
    for (int i = 1; i <= DEPTH; i++) begin
      n_cmp++; if (bus.rd_data !== ((i == DEPTH) ? 8'h55 : 8'(i))) begin
        n_err++; $display("FAIL fpp_drain: got %h want %h", bus.rd_data, (i == DEPTH) ? 8'h55 : 8'(i));
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, ack);
    end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL fpp_empty: got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_wrap();
    logic ack;
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      drive(1'b1, d, 1'b1, 1'b0, 1'b0, ack);
      n_cmp++; if (bus.count !== 5'd1 || bus.rd_data !== mq[0]) begin
        n_err++; $display("FAIL wrap: got c=%0d d=%h want c=1 d=%h", bus.count, bus.rd_data, mq[0]);
      end
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, ack);
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty: got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_saturate();
    logic ack;
    for (int i = 0; i < DEPTH + 300; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, ack);
    n_cmp++; if (bus.drop_count !== 8'd255) begin n_err++; $display("FAIL sat_drops: got %0d want 255", bus.drop_count); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %b want 1", bus.overflow); end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, ack);
    n_cmp++; if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin
      n_err++; $display("FAIL clr_alone: got o=%b n=%0d want o=0 n=0", bus.overflow, bus.drop_count);
    end
    drive(1'b1, 8'h12, 1'b0, 1'b1, 1'b0, ack);
    n_cmp++; if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd1) begin
      n_err++; $display("FAIL clr_with_drop: got o=%b n=%0d want o=1 n=1", bus.overflow, bus.drop_count);
    end
    n_cmp++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL sat_count: got %0d want 16", bus.count); end
  endtask

  task automatic test_reset_mid();
    logic ack;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, ack);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, ack);
    n_cmp++; if (bus.count !== 5'd5) begin n_err++; $display("FAIL mid_pre: got %0d want 5", bus.count); end
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL mid_ack: got %b want 0", ack); end
    n_cmp++; if (bus.count !== '0 || bus.rd_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_state: got c=%0d v=%b want c=0 v=0", bus.count, bus.rd_valid);
    end
    n_cmp++; if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin
      n_err++; $display("FAIL mid_ovf: got o=%b n=%0d want o=0 n=0", bus.overflow, bus.drop_count);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ack);
    n_cmp++; if (bus.count !== '0) begin n_err++; $display("FAIL mid_after: got %0d want 0", bus.count); end
  endtask

  task automatic test_random();
    logic ack, rx, rdy, clr;
    for (int i = 0; i < 500; i++) begin
      rx  = 1'($urandom_range(0, 99) < 60);
      rdy = 1'($urandom_range(0, 99) < 45);
      clr = 1'($urandom_range(0, 15) == 0);
      drive(rx, 8'($urandom), rdy, clr, 1'b0, ack);
      n_cmp++; if (ack !== rx) begin n_err++; $display("FAIL rnd_ack: got %b want %b", ack, rx); end
      n_cmp++; if (bus.count !== 5'(mq.size()) || bus.full !== (mq.size() == DEPTH)
                   || bus.rd_valid !== (mq.size() > 0)) begin
        n_err++; $display("FAIL rnd_level: got c=%0d f=%b v=%b want c=%0d", bus.count, bus.full, bus.rd_valid, mq.size());
      end
      if (mq.size() > 0) begin
        n_cmp++; if (bus.rd_data !== mq[0]) begin n_err++; $display("FAIL rnd_data: got %h want %h", bus.rd_data, mq[0]); end
      end
      n_cmp++; if (bus.overflow !== m_ovf || bus.drop_count !== 8'(m_drops)) begin
        n_err++; $display("FAIL rnd_ovf: got o=%b n=%0d want o=%b n=%0d", bus.overflow, bus.drop_count, m_ovf, m_drops);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_ready = 1'b0;
    bus.rx_data = 8'h00;
    bus.rd_ready = 1'b0;
    bus.overflow_clr = 1'b0;
    m_ovf = 1'b0;
    m_drops = 0;
    test_reset();
    test_basic();
    test_overflow_fill();
    test_full_push_pop();
    test_wrap();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. Each time the receiver raises `rx_ready`, the block takes `rx_data` and acknowledges it via `rx_ready_clr`. It then stores the byte in a circular FIFO and presents bytes to the host on a first-word-fall-through valid/ready port. It also reports fill level, sticky overflow, and a saturating dropped-byte count, so bytes are never silently lost between receiver and host.

## Interface
Parameters:
- `DEPTH`, 16: number of byte entries; power of two, ≥ 2.
- `ADDR_W`, 4: log2(`DEPTH`); pointer width.

Ports:
- `clk` input 1: system clock; the only clock.
- `rst` input 1: synchronous, active-high reset.
- `rx_ready` input 1: receiver byte-available flag (level; stays high until cleared).
- `rx_data` input 8: receiver byte, valid while `rx_ready` = 1.
- `rx_ready_clr` output 1: acknowledge to receiver; combinational, `rx_ready & ~rst`.
- `rd_valid` output 1: FIFO non-empty; `rd_data` is valid.
- `rd_data` output 8: oldest stored byte (first-word fall-through).
- `rd_ready` input 1: host pops the head when `rd_valid` & `rd_ready`.
- `count` output `ADDR_W+1`: current number of stored bytes, 0..`DEPTH`.
- `full` output 1: `count` == `DEPTH`.
- `overflow` output 1: sticky; a byte was dropped.
- `drop_count` output 8: number of dropped bytes, saturating at 255.
- `overflow_clr` input 1: clears `overflow` and `drop_count`.

## Operation
- Push request: `push_req = rx_ready` (and not in reset). `rx_ready_clr` follows `push_req` in the same cycle. The receiver deasserts `rx_ready` on the next edge, so each byte is seen for exactly one cycle, with no double capture.
- Pop: `pop = rd_valid & rd_ready`. The head entry is removed at the clock edge.
- Push accepted when `push_req & (~full | pop)`.
  - Writes `mem[wr_ptr] <= rx_data`.
  - `wr_ptr` increments modulo `DEPTH`; it wraps naturally at `ADDR_W` bits.
- Push dropped when `push_req & full & ~pop`.
  - The byte is discarded; storage, pointers and `count` are unchanged.
  - `overflow <= 1`.
  - `drop_count` increments unless already 255.
  - `rx_ready_clr` is still asserted, so the receiver is never stalled.
- `count` update per edge:
  - +1 on accepted push without pop.
  - −1 on pop without push.
  - Unchanged on both or neither.
- `rd_ptr` increments modulo `DEPTH` on each pop.
- Simultaneous push + pop when full: both occur, `count` stays `DEPTH`, no overflow.
- Simultaneous push + pop when `count` = 1: the head is popped and the new byte becomes the head next cycle.
- Push into an empty FIFO: no bypass. `rd_valid` rises the cycle after the push edge.
- `overflow_clr`:
  - Next edge, `overflow <= 0` and `drop_count <= 0`.
  - If a drop occurs in the same cycle, the set wins: `overflow = 1`, `drop_count = 1`.
- `rd_data = mem[rd_ptr]` (combinational read). Its value is don't-care while `rd_valid` = 0, but it must be a stable memory entry, never X-driven logic.
- No internal state machine beyond pointers and counters; there is no host-side error state.

## Timing
- Reset (synchronous, at the edge with `rst` = 1):
  - `wr_ptr`, `rd_ptr`, `count` = 0.
  - `rd_valid` = 0, `full` = 0, `overflow` = 0, `drop_count` = 0.
  - Memory contents are not cleared.
  - `rx_ready_clr` = 0 while `rst` = 1.
- Reset mid-operation discards all stored bytes. A byte presented in the reset cycle is neither stored nor counted as dropped.
- Latencies:
  - Push to `rd_valid`: 1 cycle (`rx_ready` high in cycle N gives `rd_valid` = 1 in N+1 if previously empty).
  - Pop to next head on `rd_data`: 1 cycle.
- Status outputs are registered or derived from registered `count`:
  - `full` and `rd_valid` change only at clock edges.
  - `count` and `full` reflect the state after the previous edge.
- Host may hold `rd_ready` = 1 continuously; sustained throughput is 1 byte per cycle.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 in three separate `rx_ready` pulses with `rd_ready` = 0.
  - Each `rx_ready_clr` is exactly one cycle, coincident with `rx_ready`.
  - `count` = 3.
  - With `rd_ready` = 1, `rd_data` reads 0x41, 0x42, 0x43 on successive cycles, then `rd_valid` = 0.
- Fill to `DEPTH` = 16 with 0x00..0x0F, then push 0xAA and 0xBB with `rd_ready` = 0.
  - `full` = 1, `overflow` = 1, `drop_count` = 2.
  - Drain yields exactly 0x00..0x0F.
- With the FIFO full, push 0x55 in the same cycle as a pop.
  - No overflow; `count` stays 16.
  - Draining yields 0x01..0x0F, then 0x55.
- Wrap-around: 40 push/pop pairs with random data, `rd_ready` = 1.
  - Output order equals input order.
  - `count` never exceeds 1; pointers wrap past 15 correctly.
- Overflow handling:
  - 300 drops while full gives `drop_count` = 255 (saturated).
  - `overflow_clr` alone gives `overflow` = 0 and `drop_count` = 0 next cycle.
  - `overflow_clr` coincident with a drop gives `overflow` = 1 and `drop_count` = 1.
- Assert `rst` with `count` = 5 and `rx_ready` = 1 in the same cycle.
  - Next cycle: `count` = 0, `rd_valid` = 0, `overflow` = 0, `drop_count` = 0.
  - `rx_ready_clr` is 0 during reset, and the byte is not stored.
